alu_cmd_sequencer: RTL

Initiator-side front end for the 8-bit ALU. It accepts ALU commands from a host over a valid/ready channel and buffers them in a small FIFO. It issues one command at a time to the ALU using the enable/input_ready handshake, then waits for result_ready with a timeout. It returns the result, the flags and a status word to the host over a second valid/ready channel, and chains carry and borrow between consecutive operations.

---
 rtl/alu_cmd_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Host-side command FIFO and one-at-a-time issuer for the 8-bit ALU, with result timeout
// and carry/borrow chaining between consecutive operations.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_enable,
  output logic       alu_input_ready,
  output logic       alu_carry_in,
  output logic       alu_borrow_in,
  input  logic [7:0] alu_y,
  input  logic       alu_carry_out,
  input  logic       alu_borrow_out,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  input  logic       alu_parity,
  input  logic       alu_result_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [5:0] rsp_flags,
  output logic [1:0] rsp_status,
  output logic       busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t          fifo_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [4:0]    op_q, op_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic          en_q, en_d;
  logic          carry_q, carry_d, borrow_q, borrow_d;
  logic [7:0]    rsp_y_q, rsp_y_d;
  logic [5:0]    flags_q, flags_d;
  logic [1:0]    status_q, status_d;

  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_ISSUE);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
  end

  // Operands are loaded on the IDLE->ISSUE edge so the pulse and operands coincide with ISSUE.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    en_d     = 1'b0;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    rsp_y_d  = rsp_y_q;
    flags_d  = flags_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          op_d    = head.op;
          a_d     = head.a;
          b_d     = head.b;
          en_d    = (head.op <= 5'd19);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d = '0;
        if (en_q) begin
          state_d = S_WAIT;
        end else begin
          rsp_y_d  = 8'h00;
          flags_d  = 6'h00;
          status_d = 2'b10;
          state_d  = S_RESP;
        end
      end
      S_WAIT: begin
        if (alu_result_ready) begin
          rsp_y_d  = alu_y;
          flags_d  = {alu_parity, alu_overflow, alu_negative, alu_zero, alu_borrow_out, alu_carry_out};
          status_d = 2'b00;
          carry_d  = alu_carry_out;
          borrow_d = alu_borrow_out;
          state_d  = S_RESP;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          rsp_y_d  = 8'h00;
          flags_d  = 6'h00;
          status_d = 2'b01;
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          state_d  = S_RESP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      en_q     <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      rsp_y_q  <= '0;
      flags_q  <= '0;
      status_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      en_q     <= en_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      rsp_y_q  <= rsp_y_d;
      flags_q  <= flags_d;
      status_q <= status_d;
    end
  end

  assign alu_opcode      = op_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign alu_enable      = en_q;
  assign alu_input_ready = en_q;
  assign alu_carry_in    = carry_q;
  assign alu_borrow_in   = borrow_q;
  assign rsp_valid       = (state_q == S_RESP);
  assign rsp_y           = rsp_y_q;
  assign rsp_flags       = flags_q;
  assign rsp_status      = status_q;
  assign busy            = (state_q != S_IDLE) || (count_q != '0);
endmodule
